// File: rtl/cnn_fm_reader.sv
// cnn_fm_reader
//   Streams the CNN output feature-map buffer to the host/DMA side once the
//   conv engine is finished. A start pulse launches one raster scan in
//   map/row/col order over a sync RAM with 1-cycle read latency. Read data
//   lands in a 2-entry skid FIFO whose head drives a valid/ready stream.
//
// Ports
//   clk_i      clock, rising edge
//   reset_i    synchronous active-low reset
//   start_i    one-cycle pulse, begins a full readout (ignored unless idle)
//   rd_en_o    buffer read enable
//   rd_addr_o  buffer address = (m*R_p + row)*C_p + col
//   rd_data_i  buffer data, valid the cycle after rd_en_o
//   data_o     stream data (registered FIFO head)
//   valid_o    stream valid (registered, independent of ready_i)
//   ready_i    stream ready
//   last_o     marks the final element of the scan
//   busy_o     high while a readout is in progress, through the done pulse
//   done_o     one-cycle pulse on the handshake of the final element
//
// Optional feature macro: CNN_FM_READER_RELU_EN
//   When defined, elements with the sign bit set are stored as all-zero at
//   FIFO push (so -0.0 also becomes +0.0). Timing is unchanged.

module cnn_fm_reader #(
    parameter int M_p      = 4,
    parameter int R_p      = 16,
    parameter int C_p      = 16,
    parameter int WIDTH_p  = 32,
    parameter int ADDR_W_p = (M_p * R_p * C_p > 1) ? $clog2(M_p * R_p * C_p) : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    output logic                rd_en_o,
    output logic [ADDR_W_p-1:0] rd_addr_o,
    input  logic [WIDTH_p-1:0]  rd_data_i,
    output logic [WIDTH_p-1:0]  data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int MW = (M_p > 1) ? $clog2(M_p) : 1;
    localparam int RW = (R_p > 1) ? $clog2(R_p) : 1;
    localparam int CW = (C_p > 1) ? $clog2(C_p) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q;
    logic [MW-1:0]       m_q;
    logic [RW-1:0]       row_q;
    logic [CW-1:0]       col_q;
    logic [ADDR_W_p-1:0] addr_q;
    logic                inflight_q;
    logic                inflight_last_q;
    logic [1:0]          count_q;
    logic [WIDTH_p-1:0]  fifo_data_q [2];
    logic                fifo_last_q [2];

    logic                xfer;
    logic                col_end, row_end, is_last_addr;
    logic [1:0]          occupancy;
    logic [WIDTH_p-1:0]  push_data;

    assign col_end      = (col_q == CW'(C_p - 1));
    assign row_end      = (row_q == RW'(R_p - 1));
    assign is_last_addr = col_end && row_end && (m_q == MW'(M_p - 1));

    // FIFO slots plus the read still in the RAM pipeline; never exceeds 2.
    assign occupancy = count_q + {1'b0, inflight_q};

    assign valid_o   = (count_q != 2'd0);
    assign data_o    = fifo_data_q[0];
    assign last_o    = valid_o && fifo_last_q[0];
    assign xfer      = valid_o && ready_i;
    assign done_o    = xfer && last_o;
    assign busy_o    = (state_q != IDLE);
    assign rd_addr_o = addr_q;

    // A pop this cycle frees a slot, so a read may issue even when the
    // FIFO and pipeline together hold two elements.
    assign rd_en_o = (state_q == RUN) && ((occupancy < 2'd2) || xfer);

`ifdef CNN_FM_READER_RELU_EN
    assign push_data = rd_data_i[WIDTH_p-1] ? '0 : rd_data_i;
`else
    assign push_data = rd_data_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q         <= IDLE;
            m_q             <= '0;
            row_q           <= '0;
            col_q           <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            inflight_q      <= rd_en_o;
            inflight_last_q <= is_last_addr;

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        m_q     <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        addr_q  <= '0;
                    end
                end
                RUN: begin
                    if (rd_en_o) begin
                        addr_q <= addr_q + ADDR_W_p'(1);
                        if (col_end) begin
                            col_q <= '0;
                            if (row_end) begin
                                row_q <= '0;
                                m_q   <= m_q + MW'(1);
                            end else begin
                                row_q <= row_q + RW'(1);
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                        if (is_last_addr)
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done_o)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Skid FIFO, slot 0 is the registered stream head.
            case ({inflight_q, xfer})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        fifo_data_q[0] <= push_data;
                        fifo_last_q[0] <= inflight_last_q;
                    end else begin
                        fifo_data_q[1] <= push_data;
                        fifo_last_q[1] <= inflight_last_q;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    fifo_data_q[0] <= fifo_data_q[1];
                    fifo_last_q[0] <= fifo_last_q[1];
                    count_q        <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        fifo_data_q[0] <= push_data;
                        fifo_last_q[0] <= inflight_last_q;
                    end else begin
                        fifo_data_q[0] <= fifo_data_q[1];
                        fifo_last_q[0] <= fifo_last_q[1];
                        fifo_data_q[1] <= push_data;
                        fifo_last_q[1] <= inflight_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_fm_reader.sv
module tb_cnn_fm_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef CNN_FM_READER_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: element value as it should appear on the stream.
    function automatic logic [31:0] relu_ref(input logic [31:0] x);
        if (RELU && x >= 32'h8000_0000) return 32'h0;
        return x;
    endfunction

    function automatic bit pick(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // ---------------- small instance: 2 x 2 x 2 ----------------
    logic        s_rst, s_start, s_rd_en, s_valid, s_ready, s_last, s_busy, s_done;
    logic [2:0]  s_addr;
    logic [31:0] s_rd_data, s_data;
    logic [31:0] smem [8];

    cnn_fm_reader #(.M_p(2), .R_p(2), .C_p(2), .WIDTH_p(32)) u_small (
        .clk_i(clk), .reset_i(s_rst), .start_i(s_start), .rd_en_o(s_rd_en),
        .rd_addr_o(s_addr), .rd_data_i(s_rd_data), .data_o(s_data),
        .valid_o(s_valid), .ready_i(s_ready), .last_o(s_last),
        .busy_o(s_busy), .done_o(s_done));

    always @(posedge clk) if (s_rd_en) s_rd_data <= smem[s_addr];

    // ---------------- default instance: 4 x 16 x 16 ----------------
    logic        b_rst, b_start, b_rd_en, b_valid, b_ready, b_last, b_busy, b_done;
    logic [9:0]  b_addr;
    logic [31:0] b_rd_data, b_data;
    logic [31:0] bmem [1024];

    cnn_fm_reader u_big (
        .clk_i(clk), .reset_i(b_rst), .start_i(b_start), .rd_en_o(b_rd_en),
        .rd_addr_o(b_addr), .rd_data_i(b_rd_data), .data_o(b_data),
        .valid_o(b_valid), .ready_i(b_ready), .last_o(b_last),
        .busy_o(b_busy), .done_o(b_done));

    always @(posedge clk) if (b_rd_en) b_rd_data <= bmem[b_addr];

    // ---------------- degenerate instance: 1 x 1 x 1 ----------------
    logic        d_rst, d_start, d_rd_en, d_valid, d_ready, d_last, d_busy, d_done;
    logic [0:0]  d_addr;
    logic [31:0] d_rd_data, d_data;
    logic [31:0] dmem [2];

    cnn_fm_reader #(.M_p(1), .R_p(1), .C_p(1), .WIDTH_p(32)) u_one (
        .clk_i(clk), .reset_i(d_rst), .start_i(d_start), .rd_en_o(d_rd_en),
        .rd_addr_o(d_addr), .rd_data_i(d_rd_data), .data_o(d_data),
        .valid_o(d_valid), .ready_i(d_ready), .last_o(d_last),
        .busy_o(d_busy), .done_o(d_done));

    always @(posedge clk) if (d_rd_en) d_rd_data <= dmem[d_addr];

    // Expected stream for the small instance, built by raster-scanning the
    // buffer contents in map/row/col order.
    logic [31:0] exp_q [$];

    task automatic build_exp_small();
        exp_q.delete();
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    exp_q.push_back(relu_ref(smem[(m * 2 + r) * 2 + c]));
    endtask

    // One readout on the small instance. mode selects the ready pattern,
    // restart pulses start mid-scan, abort_after>0 resets after that many
    // transfers.
    task automatic run_small(input int mode, input bit restart, input int abort_after);
        int n, rds, ndone, done_cyc;
        bit pstall;
        logic [31:0] pdata;
        logic plast;
        n = 0; rds = 0; ndone = 0; done_cyc = -1; pstall = 0; pdata = '0; plast = 0;
        @(posedge clk); #1 s_start = 1'b1; s_ready = 1'b0;
        @(posedge clk); #1 s_start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            s_ready = pick(mode, cyc);
            s_start = restart && (cyc == 6);
            @(negedge clk);
            if (pstall) begin
                chk("hold_valid", s_valid, 1);
                chk("hold_data", s_data, pdata);
                chk("hold_last", s_last, plast);
            end
            if (s_rd_en) rds++;
            if (s_valid && s_ready) begin
                if (n >= exp_q.size()) chk("xfer_count", n + 1, exp_q.size());
                else begin
                    chk("data", s_data, exp_q[n]);
                    chk("last", s_last, n == exp_q.size() - 1);
                    chk("done_on_last", s_done, n == exp_q.size() - 1);
                end
                n++;
            end else begin
                chk("done_noxfer", s_done, 0);
            end
            if (s_done) begin ndone++; done_cyc = cyc; end
            chk("outstanding", (rds - n) <= 2, 1);
            if (done_cyc >= 0 && cyc == done_cyc + 1) chk("busy_after_done", s_busy, 0);
            pstall = s_valid && !s_ready; pdata = s_data; plast = s_last;
            if (abort_after > 0 && n == abort_after) begin
                @(posedge clk); #1 s_rst = 1'b0; s_ready = 1'b1;
                @(negedge clk); chk("done_in_rst", s_done, 0);
                @(posedge clk); #1 s_rst = 1'b1;
                @(negedge clk);
                chk("abort_valid", s_valid, 0);
                chk("abort_busy", s_busy, 0);
                chk("abort_done", s_done, 0);
                chk("abort_rd_en", s_rd_en, 0);
                return;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 3) break;
            @(posedge clk); #1;
        end
        s_start = 1'b0;
        chk("n_xfers", n, exp_q.size());
        chk("n_done", ndone, 1);
    endtask

    typedef struct {
        logic [31:0] in;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [8];

    initial begin
        int first_v, done_k, n, nvalid, valid_k;

        tbl[0] = '{32'h3F80_0000, 32'h3F80_0000};
        tbl[1] = '{32'hBF80_0000, RELU ? 32'h0 : 32'hBF80_0000};
        tbl[2] = '{32'h8000_0000, RELU ? 32'h0 : 32'h8000_0000};
        tbl[3] = '{32'h4000_0000, 32'h4000_0000};
        tbl[4] = '{32'h0000_0000, 32'h0000_0000};
        tbl[5] = '{32'h7F80_0000, 32'h7F80_0000};
        tbl[6] = '{32'hFF80_0000, RELU ? 32'h0 : 32'hFF80_0000};
        tbl[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};

        s_rst = 0; b_rst = 0; d_rst = 0;
        s_start = 0; b_start = 0; d_start = 0;
        s_ready = 0; b_ready = 0; d_ready = 0;
        dmem[0] = 32'hBF80_0000; dmem[1] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", s_rd_en, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_data", s_data, 0);
        chk("rst_last", s_last, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_done", s_done, 0);
        chk("rst_big_valid", b_valid, 0);
        chk("rst_big_busy", b_busy, 0);
        @(posedge clk); #1 s_rst = 1; b_rst = 1; d_rst = 1;

        // Basic readout, buffer[a] = a
        for (int a = 0; a < 8; a++) smem[a] = a;
        build_exp_small();
        run_small(0, 0, 0);

        // Table-driven ReLU / pass-through vectors
        for (int i = 0; i < 8; i++) smem[i] = tbl[i].in;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(tbl[i].exp);
        run_small(0, 0, 0);

        // Random data under several ready patterns, plus start while busy
        for (int mode = 0; mode < 3; mode++) begin
            for (int a = 0; a < 8; a++) smem[a] = $urandom;
            build_exp_small();
            run_small(mode, 0, 0);
        end
        for (int rep = 0; rep < 3; rep++) begin
            for (int a = 0; a < 8; a++) smem[a] = $urandom;
            build_exp_small();
            run_small(2, 0, 0);
        end
        for (int a = 0; a < 8; a++) smem[a] = a;
        build_exp_small();
        run_small(1, 1, 0);

        // Reset mid-operation, then a fresh readout
        run_small(0, 0, 3);
        run_small(0, 0, 0);

        // Full-throughput timing on default parameters
        for (int a = 0; a < 1024; a++) bmem[a] = $urandom;
        b_ready = 1;
        first_v = -1; done_k = -1; n = 0;
        for (int k = 0; k < 1200; k++) begin
            @(posedge clk); #1 b_start = (k == 10);
            @(negedge clk);
            if (k == 10) chk("big_rd_en_t", b_rd_en, 0);
            if (k == 11) begin
                chk("big_busy_t1", b_busy, 1);
                chk("big_rd_en_t1", b_rd_en, 1);
            end
            if (b_valid) begin
                if (first_v < 0) first_v = k;
                if (n < 1024) chk("big_data", b_data, relu_ref(bmem[n]));
                chk("big_last", b_last, n == 1023);
                n++;
            end else if (first_v >= 0 && n < 1024) begin
                chk("big_bubble", n, 1024);
            end
            if (b_done) done_k = k;
            if (done_k >= 0 && k == done_k + 2) break;
        end
        b_start = 0;
        chk("big_first_valid", first_v, 13);
        chk("big_done_cycle", done_k, 12 + 1024);
        chk("big_n_xfers", n, 1024);

        // Degenerate single-element map
        d_ready = 1; nvalid = 0; valid_k = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1 d_start = (k == 2);
            @(negedge clk);
            if (d_valid) begin
                nvalid++; valid_k = k;
                chk("one_data", d_data, relu_ref(dmem[0]));
                chk("one_last", d_last, 1);
                chk("one_done", d_done, 1);
            end
            if (k == 7) chk("one_busy_after", d_busy, 0);
        end
        d_start = 0;
        chk("one_n_valid", nvalid, 1);
        chk("one_valid_cycle", valid_k, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_fm_reader.md
Name: cnn_fm_reader

Overview:
- Read-side counterpart of the CNN output feature-map writer.
- After the conv engine finishes, a start pulse launches this block. It raster-scans the output FM buffer (sync RAM, 1-cycle read latency) in map/row/col order.
- Each element is streamed out over a valid/ready interface to the host/DMA side, with full throughput and backpressure handled through a 2-entry skid FIFO.

Parameters:
- M_p, 4, number of output feature maps
- R_p, 16, rows per map
- C_p, 16, cols per map
- WIDTH_p, 32, element width (IEEE-754 single bit pattern)
- ADDR_W_p, $clog2(M_p*R_p*C_p), buffer address width (derived)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous, active-low reset
- start_i  in  1  one-cycle pulse; begin a full readout
- rd_en_o  out  1  buffer read enable
- rd_addr_o  out  ADDR_W_p  buffer address = (m*R_p + row)*C_p + col
- rd_data_i  in  WIDTH_p  buffer data, valid the cycle after rd_en_o
- data_o  out  WIDTH_p  stream data
- valid_o  out  1  stream valid
- ready_i  in  1  stream ready
- last_o  out  1  high with the final element (m=M_p-1, row=R_p-1, col=C_p-1)
- busy_o  out  1  high from the cycle after start is accepted until the done pulse
- done_o  out  1  one-cycle pulse, same cycle the last element handshakes

Behaviour:
- Reset (reset_i=0 at clk edge) values: state IDLE; counters 0; FIFO empty; inflight 0.
- Reset output values: rd_en_o=0, rd_addr_o=0, valid_o=0, data_o=0, last_o=0, busy_o=0, done_o=0.
- Reset mid-operation aborts the readout immediately. Buffered and in-flight data are discarded, and no done_o is issued.
- States:
  - IDLE: start_i=1 -> RUN, counters cleared.
  - RUN: issue reads. After the read of the last address issues -> DRAIN.
  - DRAIN: no reads. Last element handshakes -> IDLE with done_o=1.
- start_i is ignored outside IDLE.
- Handshake: a transfer occurs when valid_o && ready_i.
  - data_o, last_o and valid_o are held stable while valid_o=1 and ready_i=0.
  - valid_o does not depend combinationally on ready_i.
- Read issue rule (RUN only): rd_en_o=1 when (fifo_count + inflight) < 2, or when a transfer occurs this cycle.
  - inflight is 1 for the cycle after rd_en_o.
  - rd_data_i is pushed into the FIFO that cycle.
  - The FIFO never overflows.
- Counter order: col innermost, then row, then m.
  - col wraps C_p-1 -> 0 and increments row.
  - row wraps R_p-1 -> 0 and increments m.
  - Counters advance only on cycles with rd_en_o=1.
- last flag: computed at issue time and carried with the data through the FIFO.
- Latency:
  - start_i at cycle t -> first rd_en_o at t+1 -> first valid_o at t+3 (FIFO registered output).
  - With ready_i held 1, one element per cycle, no bubbles. Total M_p*R_p*C_p transfers, done_o at t+2+M_p*R_p*C_p.
- Backpressure: ready_i=0 stalls reads within ≤1 cycle. At most 2 elements are buffered.
- Degenerate case M_p*R_p*C_p=1: RUN issues one read, then goes to DRAIN. valid_o, last_o and done_o then coincide with its handshake.
- data_o passes the buffer data through bit-exact. No arithmetic is performed, except under the optional feature.

Optional Feature:
- Macro: CNN_FM_READER_RELU_EN
- Defined: ReLU is applied at FIFO push.
  - If bit WIDTH_p-1 (sign) is 1, the stored element is all-zero; otherwise it passes unchanged.
  - -0.0 (0x8000_0000) becomes 0x0000_0000.
  - Latency and throughput are unchanged.
- Undefined: data passes through bit-exact, including negative values.

Test Plan:
- Basic readout: M_p=2, R_p=2, C_p=2, buffer[a]=a. Pulse start_i, ready_i=1 -> 8 transfers with data 0..7 on consecutive cycles, last_o only on data 7, done_o in the same cycle, busy_o then 0.
- Backpressure: same setup, ready_i toggling 1,0,0,1,... and random -> data order still 0..7, no drops or duplicates, data_o stable while stalled, never more than 2 outstanding (rd_en_o count minus transfers ≤ 2).
- Start while busy: pulse start_i again mid-readout -> ignored; exactly 8 transfers and 1 done_o.
- Reset mid-operation: assert reset_i=0 after 3 transfers -> next cycle valid_o=0, busy_o=0, no done_o. A new start_i then yields a fresh 0..7 sequence.
- ReLU: buffer = {0x3F80_0000, 0xBF80_0000, 0x8000_0000, 0x4000_0000, ...}.
  - With CNN_FM_READER_RELU_EN -> outputs 0x3F80_0000, 0, 0, 0x4000_0000.
  - Without -> outputs bit-identical to the buffer.
- Full throughput timing: start_i at cycle 10 with default params -> first valid_o at cycle 13, done_o at cycle 12+1024 with ready_i held 1.
